// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default sizing for the data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned DataW    = 8;
    localparam int unsigned MemAw    = 6;
    localparam int unsigned ReqAw    = 8;
    localparam int unsigned MemDepth = 50;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the 50x8 synchronous-read data memory.
// Out-of-range requests are answered with a fault and never strobe the memory.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = mem_access_ctrl_pkg::DataW,
    parameter int unsigned MEM_AW    = mem_access_ctrl_pkg::MemAw,
    parameter int unsigned REQ_AW    = mem_access_ctrl_pkg::ReqAw,
    parameter int unsigned MEM_DEPTH = mem_access_ctrl_pkg::MemDepth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [REQ_AW-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_write,
    output logic              mem_read,
    output logic [MEM_AW-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // One extra bit so a depth equal to 2**REQ_AW cannot wrap to zero.
    localparam logic [REQ_AW:0] AddrLimit = (REQ_AW + 1)'(MEM_DEPTH);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                fault_q, fault_d;
    logic [MEM_AW-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        fault_d     = fault_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr[MEM_AW-1:0];
                    wdata_d = req_wdata;
                    fault_d = ({1'b0, req_addr} >= AddrLimit);
                    rdata_d = '0;
                    state_d = StIssue;
                end
            end
            // Faults also pass through here, strobes suppressed, so they share store latency.
            StIssue: begin
                if (fault_q) begin
                    state_d = StResp;
                end else if (write_q) begin
                    mem_write   = 1'b1;
                    mem_address = addr_q;
                    mem_data_in = wdata_q;
                    state_d     = StResp;
                end else begin
                    mem_read    = 1'b1;
                    mem_address = addr_q;
                    state_d     = StWait;
                end
            end
            StWait: begin
                rdata_d = mem_data_out;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous-read memory behind it.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       resp_valid, resp_ready, resp_fault;
    logic [7:0] resp_rdata;
    logic       mem_write, mem_read;
    logic [5:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [0:63];
    int wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0, cyc = 0;
    int acc_cyc[$];
    logic [7:0] resp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Downstream memory model: write at the edge, registered read data.
    always @(posedge clk) begin
        if (mem_write) mem_model[mem_address] <= mem_data_in;
        if (mem_read)  mem_data_out <= mem_model[mem_address];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
        if (mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_write && mem_read) overlap_cnt <= overlap_cnt + 1;
        if (rst_n && req_valid && req_ready) acc_cyc.push_back(cyc);
        if (rst_n && resp_valid && resp_ready) resp_q.push_back(resp_rdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic w, input logic [7:0] a, input logic [7:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 8'h3F;
        req_wdata = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b want=0", resp_valid); end
        checks++; if (resp_rdata !== 8'h00) begin failures++; $display("FAIL reset_resp_rdata got=%h want=00", resp_rdata); end
        checks++; if (resp_fault !== 1'b0) begin failures++; $display("FAIL reset_resp_fault got=%0b want=0", resp_fault); end
        checks++; if ({mem_write, mem_read} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b want=00", {mem_write, mem_read}); end
        checks++; if ({mem_address, mem_data_in} !== 14'h0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h want=0/0", mem_address, mem_data_in); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store();
        int w0;
        w0 = wr_cnt;
        resp_ready = 1'b1;
        do_accept(1'b1, 8'd7, 8'hA5);
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL store_strobe got=wr%0b rd%0b want=wr1 rd0", mem_write, mem_read); end
        checks++; if (mem_address !== 6'd7 || mem_data_in !== 8'hA5) begin failures++; $display("FAIL store_bus got=%0d/%h want=7/a5", mem_address, mem_data_in); end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL store_issue_hs got=v%0b r%0b want=v0 r0", resp_valid, req_ready); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 8'h00) begin failures++; $display("FAIL store_resp got=v%0b f%0b d%h want=v1 f0 d00", resp_valid, resp_fault, resp_rdata); end
        checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL store_strobe_drop got=%0b want=0", mem_write); end
        checks++; if (mem_model[7] !== 8'hA5) begin failures++; $display("FAIL store_mem got=%h want=a5", mem_model[7]); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL store_idle got=v%0b r%0b want=v0 r1", resp_valid, req_ready); end
        checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL store_strobe_len got=%0d want=1", wr_cnt - w0); end
    endtask

    task automatic test_load();
        resp_ready = 1'b1;
        do_accept(1'b1, 8'd49, 8'h3C);
        tick();
        tick();
        do_accept(1'b0, 8'd49, 8'h00);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 6'd49) begin failures++; $display("FAIL load_issue got=rd%0b wr%0b a%0d want=rd1 wr0 a49", mem_read, mem_write, mem_address); end
        tick();
        checks++; if (resp_valid !== 1'b0 || mem_read !== 1'b0) begin failures++; $display("FAIL load_wait got=v%0b rd%0b want=v0 rd0", resp_valid, mem_read); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 8'h3C || resp_fault !== 1'b0) begin failures++; $display("FAIL load_resp got=v%0b d%h f%0b want=v1 d3c f0", resp_valid, resp_rdata, resp_fault); end
        tick();
    endtask

    task automatic test_fault();
        logic [7:0] a;
        int r0, w0;
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a  = (i == 0) ? 8'd50 : 8'hC1;
            r0 = rd_cnt;
            w0 = wr_cnt;
            do_accept(1'b0, a, 8'h00);
            checks++; if (resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL fault_issue a=%h got=v%0b rd%0b wr%0b want=v0 rd0 wr0", a, resp_valid, mem_read, mem_write); end
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 8'h00) begin failures++; $display("FAIL fault_resp a=%h got=v%0b f%0b d%h want=v1 f1 d00", a, resp_valid, resp_fault, resp_rdata); end
            tick();
            checks++; if (rd_cnt != r0 || wr_cnt != w0) begin failures++; $display("FAIL fault_no_strobe a=%h got=rd%0d wr%0d want=rd0 wr0", a, rd_cnt - r0, wr_cnt - w0); end
        end
    endtask

    task automatic test_backpressure();
        int w0, bad;
        resp_ready = 1'b1;
        do_accept(1'b1, 8'd3, 8'h5A);
        tick();
        tick();
        resp_ready = 1'b0;
        do_accept(1'b0, 8'd3, 8'h00);
        tick();
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 8'h5A) begin failures++; $display("FAIL bp_first got=v%0b d%h want=v1 d5a", resp_valid, resp_rdata); end
        w0 = wr_cnt;
        bad = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd10; req_wdata = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_rdata !== 8'h5A || req_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable cycles want=0", bad); end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=v%0b r%0b want=v0 r1", resp_valid, req_ready); end
        checks++; if (wr_cnt != w0 || mem_model[10] !== 8'h00) begin failures++; $display("FAIL bp_ignored_req got=wr%0d m%h want=wr0 m00", wr_cnt - w0, mem_model[10]); end
    endtask

    task automatic test_back_to_back();
        logic       tw [3];
        logic [7:0] ta [3];
        logic [7:0] td [3];
        int n, k, o0;
        tw = '{1'b1, 1'b0, 1'b1};
        ta = '{8'd20, 8'd20, 8'd21};
        td = '{8'h11, 8'h00, 8'h22};
        o0 = overlap_cnt;
        acc_cyc.delete();
        resp_q.delete();
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_write = tw[i]; req_addr = ta[i]; req_wdata = td[i]; req_valid = 1'b1;
            n = acc_cyc.size();
            k = 0;
            while (acc_cyc.size() == n && k < 20) begin
                tick();
                k++;
            end
            checks++; if (acc_cyc.size() == n) begin failures++; $display("FAIL b2b_accept_timeout item=%0d got=none want=accept", i); end
        end
        req_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (acc_cyc.size() != 3) begin
            failures++; $display("FAIL b2b_accept_count got=%0d want=3", acc_cyc.size());
        end else if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 4) begin
            failures++; $display("FAIL b2b_interval got=%0d,%0d want=3,4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        checks++;
        if (resp_q.size() != 3 || resp_q[1] !== 8'h11) begin
            failures++; $display("FAIL b2b_load_data got=n%0d d%h want=n3 d11", resp_q.size(), (resp_q.size() > 1) ? resp_q[1] : 8'hXX);
        end
        checks++; if (overlap_cnt != o0 || mem_model[21] !== 8'h22) begin failures++; $display("FAIL b2b_overlap_mem got=ov%0d m%h want=ov0 m22", overlap_cnt - o0, mem_model[21]); end
    endtask

    task automatic test_reset_mid_issue();
        int bad;
        resp_ready = 1'b0;
        do_accept(1'b0, 8'd7, 8'h00);
        checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_pre_issue got=%0b want=1", mem_read); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_write, mem_read} !== 2'b00 || mem_address !== 6'd0 || mem_data_in !== 8'h00) begin failures++; $display("FAIL rst_async_strobes got=wr%0b rd%0b a%0d d%h want=0 0 0 00", mem_write, mem_read, mem_address, mem_data_in); end
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 8'h00 || resp_fault !== 1'b0) begin failures++; $display("FAIL rst_async_outputs got=r%0b v%0b d%h f%0b want=r1 v0 d00 f0", req_ready, resp_valid, resp_rdata, resp_fault); end
        tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            tick();
            if (resp_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_no_resp got=vcyc%0d r%0b want=vcyc0 r1", bad, req_ready); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;
        mem_data_out = 8'h00;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 8'h00;
        req_wdata  = 8'h00;
        resp_ready = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
